sld_decode_scheduler: RTL and testbench

//  Shares one SECOND_LEVEL_DECODER (RS over GF(16): 8 value + 4 parity symbols) among NUM_REQ requesters.

---
 rtl/sld_pkg.sv | 37 +++
 rtl/sld_rr_arbiter.sv | 30 +++
 rtl/sld_second_level_decoder.sv | 32 +++
 rtl/sld_decode_scheduler.sv | 131 +++++++++++++
 tb/tb_sld_decode_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sld_pkg.sv
// Shared types and GF(16) helpers for the second-level decode scheduler.
// Field polynomial is x^4 + x + 1; alpha is 4'h2.
package sld_pkg;

  localparam int SYM_W  = 4;
  localparam int NUM_VP = 8;
  localparam int NUM_PP = 4;
  localparam int VP_W   = NUM_VP * SYM_W;
  localparam int PP_W   = NUM_PP * SYM_W;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} sld_state_e;

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t r;
    sym_t x;
    r = '0;
    x = a;
    for (int k = 0; k < SYM_W; k++) begin
      if (b[k]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  // Fixed loop bound keeps this usable in synthesised logic; callers pass elaboration constants.
  function automatic sym_t gf_pow(input int e);
    sym_t r;
    r = 4'h1;
    for (int k = 0; k < 15; k++) begin
      if (k < (e % 15)) r = gf_mul(r, 4'h2);
    end
    return r;
  endfunction

endpackage

// File: rtl/sld_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or above ptr, wrapping.
module sld_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sld_second_level_decoder.sv
// RS(12,8) decoder over GF(16), generator roots alpha^0..alpha^3; value symbols at positions 0..7,
// parity at 8..11. Corrects one symbol error; other nonzero-syndrome patterns pass vp through.
module SECOND_LEVEL_DECODER
  import sld_pkg::*;
(
  input  sym_t vp_in  [NUM_VP],
  input  sym_t pp_in  [NUM_PP],
  output sym_t vp_out [NUM_VP]
);

  sym_t cw  [NUM_VP+NUM_PP];
  sym_t syn [4];
  logic single;

  always_comb begin
    for (int j = 0; j < NUM_VP; j++) cw[j] = vp_in[j];
    for (int k = 0; k < NUM_PP; k++) cw[NUM_VP+k] = pp_in[k];
    for (int i = 0; i < 4; i++) begin
      syn[i] = '0;
      for (int j = 0; j < NUM_VP + NUM_PP; j++) syn[i] = syn[i] ^ gf_mul(cw[j], gf_pow(i * j));
    end
    // A single error makes consecutive syndromes a geometric series with ratio alpha^pos.
    single = (syn[0] != '0) &&
             (gf_mul(syn[1], syn[1]) == gf_mul(syn[0], syn[2])) &&
             (gf_mul(syn[2], syn[2]) == gf_mul(syn[1], syn[3]));
    for (int j = 0; j < NUM_VP; j++) begin
      vp_out[j] = vp_in[j];
      if (single && (gf_mul(syn[0], gf_pow(j)) == syn[1])) vp_out[j] = vp_in[j] ^ syn[0];
    end
  end

endmodule

// File: rtl/sld_decode_scheduler.sv
// Round-robin scheduler sharing one second-level decoder among NUM_REQ first-level lanes.
// The captured codeword is held on the decoder for DEC_LAT cycles before the result is registered.
module sld_decode_scheduler
  import sld_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*VP_W-1:0]      req_vp,
  input  logic [NUM_REQ*PP_W-1:0]      req_pp,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [VP_W-1:0]              resp_vp,
  output logic                         resp_corrected,
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             corr_cnt,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int LAT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sld_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cap_id;
  logic [ID_W-1:0]   gnt_idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_any;
  logic [VP_W-1:0]   cap_vp;
  logic [VP_W-1:0]   dec_vp_flat;
  logic [PP_W-1:0]   cap_pp;
  sym_t              dec_vp_in  [NUM_VP];
  sym_t              dec_pp_in  [NUM_PP];
  sym_t              dec_vp_out [NUM_VP];

  sld_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;

  for (genvar k = 0; k < NUM_VP; k++) begin : g_vp
    assign dec_vp_in[k]                     = cap_vp[SYM_W*k +: SYM_W];
    assign dec_vp_flat[SYM_W*k +: SYM_W]    = dec_vp_out[k];
  end

  for (genvar k = 0; k < NUM_PP; k++) begin : g_pp
    assign dec_pp_in[k] = cap_pp[SYM_W*k +: SYM_W];
  end

  SECOND_LEVEL_DECODER u_dec (
    .vp_in  (dec_vp_in),
    .pp_in  (dec_pp_in),
    .vp_out (dec_vp_out)
  );

  // Capture registers are only written on accept, so the decoder input is stable for the whole BUSY window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      lat_cnt        <= '0;
      cap_id         <= '0;
      cap_vp         <= '0;
      cap_pp         <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_vp        <= '0;
      resp_corrected <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cap_vp  <= req_vp[gnt_idx*VP_W +: VP_W];
            cap_pp  <= req_pp[gnt_idx*PP_W +: PP_W];
            cap_id  <= gnt_idx;
            rr_ptr  <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            lat_cnt <= LAT_W'(DEC_LAT - 1);
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            resp_vp        <= dec_vp_flat;
            resp_corrected <= (dec_vp_flat != cap_vp);
            resp_id        <= cap_id;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear in the same cycle as a corrected handshake leaves the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
    end else if (resp_valid && resp_ready && resp_corrected && (corr_cnt != CNT_MAX)) begin
      corr_cnt <= corr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sld_decode_scheduler.sv
// Directed scoreboard bench for sld_decode_scheduler; a negedge monitor pops expected responses.
module tb_sld_decode_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DEC_LAT = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  // g(x) = x^4 + F x^3 + 3 x^2 + x + C: a nonzero codeword with all-zero parity.
  localparam logic [31:0] CW = 32'h0001_F31C;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_vp = '0;
  logic [NUM_REQ*16-1:0] req_pp = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [1:0]           resp_id;
  logic [31:0]          resp_vp;
  logic                 resp_corrected;
  logic                 cnt_clr = 1'b0;
  logic [CNT_W-1:0]     corr_cnt;
  logic                 busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] vp;
    logic        corr;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   exp_cnt = 0;

  sld_decode_scheduler #(.NUM_REQ(NUM_REQ), .DEC_LAT(DEC_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vp         (req_vp),
    .req_pp         (req_pp),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_vp        (resp_vp),
    .resp_corrected (resp_corrected),
    .cnt_clr        (cnt_clr),
    .corr_cnt       (corr_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  // Scoreboard monitor plus a reference model of the saturating corrected counter.
  always @(negedge clk) begin
    exp_t e;
    logic hs_corr;
    hs_corr = 1'b0;
    if (rst) begin
      exp_cnt = 0;
    end else begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: got id %0d vp %0h expected no response", resp_id, resp_vp);
        end else begin
          e = exp_q.pop_front();
          check_output("resp_id", 32'(resp_id), 32'(e.id));
          check_output("resp_vp", resp_vp, e.vp);
          check_output("resp_corrected", 32'(resp_corrected), 32'(e.corr));
          hs_corr = e.corr;
        end
      end
      if (cnt_clr) exp_cnt = 0;
      else if (hs_corr && exp_cnt != CNT_MAX) exp_cnt++;
    end
  end

  task automatic apply_stimulus(input int id, input logic [31:0] vp, input logic [15:0] pp,
                                input logic [31:0] exp_vp, input logic exp_corr);
    int n;
    @(posedge clk); #1;
    req_valid[id]        = 1'b1;
    req_vp[32*id +: 32]  = vp;
    req_pp[16*id +: 16]  = pp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 60);
    if (!req_ready[id]) timeout_fail("accept_timeout");
    else exp_q.push_back('{id: 2'(id), vp: exp_vp, corr: exp_corr});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout_fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_resp_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 60);
    if (!resp_valid) timeout_fail("resp_timeout");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] vp_tmp;

    #12;
    check_output("rst_req_ready", 32'(req_ready), 32'h0);
    check_output("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_output("rst_resp_id", 32'(resp_id), 32'h0);
    check_output("rst_resp_vp", resp_vp, 32'h0);
    check_output("rst_resp_corr", 32'(resp_corrected), 32'h0);
    check_output("rst_corr_cnt", 32'(corr_cnt), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero codeword from requester 0 and response latency.
    apply_stimulus(0, 32'h0, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("lat_c1_valid", 32'(resp_valid), 32'h0);
    check_output("lat_c1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_output("lat_c2_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    check_output("lat_c3_valid", 32'(resp_valid), 32'h1);
    drain();

    // Single symbol error from requester 2, then a parity-only error from requester 3.
    apply_stimulus(2, 32'h0000_5000, 16'h0, 32'h0, 1'b1);
    drain();
    check_output("corr_cnt_t2", 32'(corr_cnt), 32'h1);
    apply_stimulus(3, CW, 16'h0040, CW, 1'b0);
    drain();

    // All requesters valid continuously: grants rotate 0,1,2,3,0.
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      vp_tmp = (32'h9 - 32'(i)) << (8 * i);
      req_vp[32*i +: 32] = vp_tmp;
      req_pp[16*i +: 16] = 16'h0;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        check_output("ready_onehot", 32'($countones(req_ready) <= 1), 32'h1);
      end while (req_ready == '0 && n < 60);
      check_output("grant_order", 32'(req_ready), 32'h1 << (k % NUM_REQ));
      exp_q.push_back('{id: 2'(k % NUM_REQ), vp: 32'h0, corr: 1'b1});
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
    check_output("corr_cnt_t3", 32'(corr_cnt), 32'h6);

    // Backpressure in RESP: outputs hold and nothing new is accepted.
    resp_ready = 1'b0;
    apply_stimulus(1, CW ^ 32'h0300_0000, 16'h0, CW, 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_vp[31:0] = 32'h0;
    wait_resp_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output("hold_valid", 32'(resp_valid), 32'h1);
      check_output("hold_vp", resp_vp, CW);
      check_output("hold_id", 32'(resp_id), 32'h1);
      check_output("hold_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    resp_ready   = 1'b1;
    drain();
    check_output("corr_cnt_t4", 32'(corr_cnt), 32'h7);

    // Reset during BUSY drops the request and restarts arbitration at requester 0.
    @(posedge clk); #1;
    req_valid[2]    = 1'b1;
    req_vp[64 +: 32] = 32'h0000_0D00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[2] && n < 60);
    if (!req_ready[2]) timeout_fail("accept_timeout_t5");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check_output("t5_busy_before", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_output("t5_resp_valid", 32'(resp_valid), 32'h0);
    check_output("t5_busy", 32'(busy), 32'h0);
    check_output("t5_corr_cnt", 32'(corr_cnt), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output("t5_no_resp", 32'(resp_valid), 32'h0);
    end
    @(posedge clk); #1;
    req_vp[32 +: 32] = CW;
    req_vp[96 +: 32] = 32'h0000_0070;
    req_valid = 4'b1010;
    @(negedge clk);
    check_output("t5_first_grant", 32'(req_ready), 32'h2);
    exp_q.push_back('{id: 2'd1, vp: CW, corr: 1'b0});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 60);
    check_output("t5_second_grant", 32'(req_ready), 32'h8);
    exp_q.push_back('{id: 2'd3, vp: 32'h0, corr: 1'b1});
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    drain();
    check_output("corr_cnt_t5", 32'(corr_cnt), 32'h1);

    // Counter clear, saturation, and clear winning over a corrected handshake.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check_output("cnt_clr_alone", 32'(corr_cnt), 32'h0);
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(k % NUM_REQ, 32'h1 << (4 * (k % 8)), 16'h0, 32'h0, 1'b1);
    end
    drain();
    check_output("cnt_saturate", 32'(corr_cnt), 32'(CNT_MAX));
    check_output("cnt_model", 32'(corr_cnt), 32'(exp_cnt));
    resp_ready = 1'b0;
    apply_stimulus(0, 32'h2000_0000, 16'h0, 32'h0, 1'b1);
    wait_resp_valid();
    check_output("cnt_before_clr", 32'(corr_cnt), 32'(CNT_MAX));
    @(posedge clk); #1;
    resp_ready = 1'b1;
    cnt_clr    = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check_output("cnt_clr_wins", 32'(corr_cnt), 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
